// File: rtl/bus_cycle_seq_if.sv
// rtl/bus_cycle_seq_if.sv - request and multiplexed AD bus signals of the bus cycle sequencer
interface bus_cycle_seq_if;
  logic        start;
  logic        wr;
  logic        io;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic [7:0]  ad_in;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [7:0]  a_hi;
  logic        ale;
  logic        rd_n;
  logic        wr_n;
  logic        io_m;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  rdata;
  logic        rdata_en;

  // master: the sequencer driving the bus; slave: the requester and bus environment
  modport master (
    input  start, wr, io, addr, wdata, ready, ad_in,
    output ad_out, ad_oe, a_hi, ale, rd_n, wr_n, io_m, busy, done, err, rdata, rdata_en
  );

  modport slave (
    output start, wr, io, addr, wdata, ready, ad_in,
    input  ad_out, ad_oe, a_hi, ale, rd_n, wr_n, io_m, busy, done, err, rdata, rdata_en
  );
endinterface

// File: rtl/bus_cycle_seq.sv
// rtl/bus_cycle_seq.sv - T1/T2/TW/T3 machine-cycle sequencer for a multiplexed 8-bit AD bus
module bus_cycle_seq #(
  parameter int unsigned WAIT_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  bus_cycle_seq_if.master  bus
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        wr_q, wr_d;
  logic        io_q, io_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic [7:0]  ad_out_q, ad_out_d;
  logic        ad_oe_q, ad_oe_d;
  logic [7:0]  a_hi_q, a_hi_d;
  logic        ale_q, ale_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        io_m_q, io_m_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdata_en_q, rdata_en_d;

  logic        timeout;

  assign timeout = (state_q == S_TW) && !bus.ready && (LIMIT != 8'd0) && (wait_cnt_q == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = bus.ready ? S_T3 : S_TW;
      S_TW: begin
        if (timeout)        state_d = S_IDLE;
        else if (bus.ready) state_d = S_T3;
        else                state_d = S_TW;
      end
      S_T3:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are captured only on the IDLE->T1 edge so start during a cycle has no effect
  always_comb begin
    wr_d       = wr_q;
    io_d       = io_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    if (state_q == S_IDLE && bus.start) begin
      wr_d    = bus.wr;
      io_d    = bus.io;
      addr_d  = bus.addr;
      wdata_d = bus.wdata;
    end
    if (state_d == S_T1) begin
      wait_cnt_d = 8'd0;
    end else if ((state_q == S_T2 || state_q == S_TW) && state_d == S_TW) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Outputs are decoded from the next state so that the registered pins line up with the state
  always_comb begin
    ad_out_d   = ad_out_q;
    ad_oe_d    = 1'b0;
    a_hi_d     = a_hi_q;
    ale_d      = 1'b0;
    rd_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    io_m_d     = io_m_q;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_q == S_T3);
    err_d      = timeout;
    rdata_en_d = (state_q == S_T3) && !wr_q;
    rdata_d    = ((state_q == S_T3) && !wr_q) ? bus.ad_in : rdata_q;
    case (state_d)
      S_T1: begin
        ale_d    = 1'b1;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d[7:0];
        a_hi_d   = addr_d[15:8];
        io_m_d   = io_d;
      end
      S_T2, S_TW, S_T3: begin
        if (wr_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
          wr_n_d   = 1'b0;
        end else begin
          rd_n_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= 8'd0;
      wr_q       <= 1'b0;
      io_q       <= 1'b0;
      addr_q     <= 16'd0;
      wdata_q    <= 8'd0;
      ad_out_q   <= 8'd0;
      ad_oe_q    <= 1'b0;
      a_hi_q     <= 8'd0;
      ale_q      <= 1'b0;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      io_m_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 8'd0;
      rdata_en_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      wr_q       <= wr_d;
      io_q       <= io_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ad_out_q   <= ad_out_d;
      ad_oe_q    <= ad_oe_d;
      a_hi_q     <= a_hi_d;
      ale_q      <= ale_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      io_m_q     <= io_m_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      rdata_en_q <= rdata_en_d;
    end
  end

  assign bus.ad_out   = ad_out_q;
  assign bus.ad_oe    = ad_oe_q;
  assign bus.a_hi     = a_hi_q;
  assign bus.ale      = ale_q;
  assign bus.rd_n     = rd_n_q;
  assign bus.wr_n     = wr_n_q;
  assign bus.io_m     = io_m_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rdata    = rdata_q;
  assign bus.rdata_en = rdata_en_q;

endmodule

// File: tb/tb_bus_cycle_seq.sv
// tb/tb_bus_cycle_seq.sv - randomized bench for bus_cycle_seq with a cycle-count reference model
module tb_bus_cycle_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, wr, io, ready;
  logic [15:0] addr;
  logic [7:0]  wdata, ad_in;

  always #5 clk = ~clk;

  bus_cycle_seq_if bif8 ();
  bus_cycle_seq_if bif2 ();

  assign bif8.start = start;  assign bif2.start = start;
  assign bif8.wr    = wr;     assign bif2.wr    = wr;
  assign bif8.io    = io;     assign bif2.io    = io;
  assign bif8.addr  = addr;   assign bif2.addr  = addr;
  assign bif8.wdata = wdata;  assign bif2.wdata = wdata;
  assign bif8.ready = ready;  assign bif2.ready = ready;
  assign bif8.ad_in = ad_in;  assign bif2.ad_in = ad_in;

  bus_cycle_seq #(.WAIT_LIMIT(8)) dut8 (.clk(clk), .rst(rst), .bus(bif8.master));
  bus_cycle_seq #(.WAIT_LIMIT(2)) dut2 (.clk(clk), .rst(rst), .bus(bif2.master));

  typedef struct packed {
    logic       busy, done, err, rdata_en, ale, ad_oe, rd_n, wr_n, io_m;
    logic [7:0] a_hi, ad_out, rdata;
  } snap_t;

  // ad_out is only meaningful while the bus is driven
  snap_t s8, s2;
  assign s8 = {bif8.busy, bif8.done, bif8.err, bif8.rdata_en, bif8.ale, bif8.ad_oe, bif8.rd_n,
               bif8.wr_n, bif8.io_m, bif8.a_hi, (bif8.ad_oe ? bif8.ad_out : 8'h00), bif8.rdata};
  assign s2 = {bif2.busy, bif2.done, bif2.err, bif2.rdata_en, bif2.ale, bif2.ad_oe, bif2.rd_n,
               bif2.wr_n, bif2.io_m, bif2.a_hi, (bif2.ad_oe ? bif2.ad_out : 8'h00), bif2.rdata};

  int          total = 0;
  int          bad = 0;
  int          lim [2] = '{8, 2};
  logic [7:0]  m_a_hi [2];
  logic        m_io_m [2];
  logic [7:0]  m_rdata [2];
  logic [65:0] obs_q [$];
  logic [65:0] exp_q [$];

  function automatic snap_t rst_snap();
    snap_t s;
    s = '0;
    s.rd_n = 1'b1;
    s.wr_n = 1'b1;
    return s;
  endfunction

  function automatic snap_t idle_snap(input int d, input logic dn, input logic er, input logic en);
    snap_t s;
    s = rst_snap();
    s.io_m = m_io_m[d];
    s.a_hi = m_a_hi[d];
    s.rdata = m_rdata[d];
    s.done = dn;
    s.err = er;
    s.rdata_en = en;
    return s;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_a_hi[d] = 8'h00;
      m_io_m[d] = 1'b0;
      m_rdata[d] = 8'h00;
    end
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One machine cycle on both DUTs; ready is low for the first nlow samples.
  // The model only knows the cycle length: 3 + waits, or 2 + limit when the limit is hit.
  task automatic run_txn(input logic t_wr, input logic t_io, input logic [15:0] t_addr,
                         input logic [7:0] t_wdata, input int nlow, input bit hold, input int adin_fix);
    int         nb [2];
    bit         ab [2];
    int         last;
    logic [7:0] adin_hist [$];
    snap_t      e [2];
    start = 1'b1;
    wr = t_wr;
    io = t_io;
    addr = t_addr;
    wdata = t_wdata;
    last = 0;
    for (int d = 0; d < 2; d++) begin
      ab[d] = (lim[d] > 0) && (nlow > lim[d]);
      nb[d] = ab[d] ? 2 + lim[d] : 3 + nlow;
      if (nb[d] + 1 > last) last = nb[d] + 1;
    end
    adin_hist.push_back(8'h00);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (c == 1) begin
          m_a_hi[d] = t_addr[15:8];
          m_io_m[d] = t_io;
          e[d] = idle_snap(d, 1'b0, 1'b0, 1'b0);
          e[d].busy = 1'b1;
          e[d].ale = 1'b1;
          e[d].ad_oe = 1'b1;
          e[d].ad_out = t_addr[7:0];
        end else if (c <= nb[d]) begin
          e[d] = idle_snap(d, 1'b0, 1'b0, 1'b0);
          e[d].busy = 1'b1;
          if (t_wr) begin
            e[d].wr_n = 1'b0;
            e[d].ad_oe = 1'b1;
            e[d].ad_out = t_wdata;
          end else begin
            e[d].rd_n = 1'b0;
          end
        end else if (c == nb[d] + 1) begin
          if (!ab[d] && !t_wr) m_rdata[d] = adin_hist[nb[d]];
          e[d] = idle_snap(d, !ab[d], ab[d], !ab[d] && !t_wr);
        end else begin
          e[d] = idle_snap(d, 1'b0, 1'b0, 1'b0);
        end
      end
      obs_q.push_back({s8, s2});
      exp_q.push_back({e[0], e[1]});
      start = hold;
      ready = (c > nlow + 1);
      ad_in = (adin_fix >= 0) ? adin_fix[7:0] : 8'($urandom);
      adin_hist.push_back(ad_in);
    end
  endtask

  task automatic test_reset();
    snap_t r;
    r = rst_snap();
    rst = 1'b0;
    start = 1'b0; wr = 1'b0; io = 1'b0; addr = 16'h0; wdata = 8'h0; ready = 1'b1; ad_in = 8'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({s8, s2} !== {r, r}) begin
      bad++;
      $display("FAIL reset_state actual=%h required=%h", {s8, s2}, {r, r});
    end
    total++;
    if ({bif8.ad_out, bif2.ad_out} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_ad_out actual=%h required=0000", {bif8.ad_out, bif2.ad_out});
    end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_read();
    run_txn(1'b0, 1'b0, 16'h2050, 8'h00, 0, 1'b0, 8'hA5);
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL read cyc%0d actual=%h required=%h", i + 1, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (bif8.rdata !== 8'hA5) begin
      bad++;
      $display("FAIL read_rdata actual=%h required=a5", bif8.rdata);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_write();
    run_txn(1'b1, 1'b1, 16'h0042, 8'h3C, 0, 1'b0, -1);
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL write cyc%0d actual=%h required=%h", i + 1, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_wait();
    run_txn(1'b0, 1'b0, 16'h1234, 8'h00, 3, 1'b0, -1);
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL wait3 cyc%0d actual=%h required=%h", i + 1, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 1'b1, 16'hBEEF, 8'h00, 20, 1'b0, -1);
    run_txn(1'b1, 1'b0, 16'h7711, 8'h99, 9, 1'b0, -1);
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL timeout cyc%0d actual=%h required=%h", i + 1, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      run_txn(k[0], 1'b0, 16'($urandom), 8'($urandom), 0, (k != 3), -1);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b cyc%0d actual=%h required=%h", i + 1, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    snap_t r;
    r = rst_snap();
    start = 1'b1; wr = 1'b0; io = 1'b1; addr = 16'hC3A7; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({bif8.rd_n, bif8.busy, bif2.rd_n, bif2.busy} !== 4'b0101) begin
      bad++;
      $display("FAIL midrst_in_t2 actual=%b required=0101", {bif8.rd_n, bif8.busy, bif2.rd_n, bif2.busy});
    end
    rst = 1'b0;
    #1;
    total++;
    if ({s8, s2} !== {r, r}) begin
      bad++;
      $display("FAIL midrst_async actual=%h required=%h", {s8, s2}, {r, r});
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      total++;
      if ({s8, s2} !== {r, r}) begin
        bad++;
        $display("FAIL midrst_idle%0d actual=%h required=%h", k, {s8, s2}, {r, r});
      end
    end
    run_txn(1'b0, 1'b0, 16'h5A5A, 8'h00, 1, 1'b0, -1);
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL midrst_next cyc%0d actual=%h required=%h", i + 1, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int nlow;
    bit hold;
    for (int k = 0; k < 40; k++) begin
      nlow = $urandom_range(0, 10);
      hold = (nlow <= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_txn(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), nlow, hold, -1);
      if (!hold && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL random idx%0d actual=%h required=%h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    idle(2);
    test_write();
    idle(1);
    test_wait();
    idle(2);
    test_timeout();
    idle(1);
    test_back_to_back();
    idle(2);
    test_reset_mid();
    idle(1);
    test_random();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
